mem_access: RTL and testbench
=============================

# mem_access

Parametrised successor to the pass-through MEM stage of the pipeline. It sits between the EX/MEM and MEM/WB pipeline registers. It performs load/store accesses on a req/ack data bus, applies big-endian byte-lane selection and load sign/zero extension, and stalls the pipeline while a transaction is outstanding. Register-file and HI/LO write-back information passes through unchanged for non-memory instructions.

## Interface
- `AW`, default 32: data-bus address width; `mem_addr_i[1:0]` always select the byte lane.
- `REG_AW`, default 5: register-file address width.
- `WAIT_MAX`, default 15: bus-ack timeout in cycles, in the range 1..255.
- Data width is fixed at 32 bits (`RegBus`).

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset (`RstEnable`).
- `wd_i` in REG_AW, `wreg_i` in 1, `wdata_i` in 32: write-back destination, enable and data from EX.
- `hi_i` in 32, `lo_i` in 32, `whilo_i` in 1: HI/LO write-back from EX.
- `mem_op_i` in 4: operation code.
  - 0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC.
  - Any other value is treated as NOP.
- `mem_addr_i` in AW, `mem_sdata_i` in 32: effective address and store data.
- `llbit_clr_i` in 1: clears the LL bit (exception/ERET). Present only when `MEM_LLSC_EN` is defined.
- `wd_o` out REG_AW, `wreg_o` out 1, `wdata_o` out 32: write-back to the MEM/WB register.
- `hi_o` out 32, `lo_o` out 32, `whilo_o` out 1: HI/LO write-back.
- `stallreq_o` out 1: pipeline stall request. EX/MEM holds all inputs stable while this is 1.
- `bus_req_o` out 1 (registered), `bus_we_o` out 1, `bus_addr_o` out AW, `bus_sel_o` out 4, `bus_wdata_o` out 32: data-bus request.
- `bus_rdata_i` in 32, `bus_ack_i` in 1: data-bus response.
- `align_err_o` out 1: misaligned-access flag.
- `bus_err_o` out 1: one-cycle pulse on bus timeout.

## Operation
- FSM states: IDLE, BUS, DONE.
- NOP in IDLE:
  - All write-back and HI/LO outputs equal their inputs combinationally.
  - `stallreq_o` = 0. Zero added latency.
- Valid memory op in IDLE:
  - `stallreq_o` = 1 combinationally; next state BUS.
  - Bus address, write enable, byte select and write data are latched.
- BUS:
  - `bus_req_o` = 1 and `stallreq_o` = 1; the wait counter increments each cycle.
  - On `bus_ack_i`: `bus_rdata_i` is captured and the next state is DONE.
  - If the counter reaches WAIT_MAX with no ack: next state DONE and `bus_err_o` pulses in the DONE cycle.
- DONE:
  - `stallreq_o` = 0 and outputs are valid.
  - Loads: `wdata_o` = extended captured data and `wreg_o` = `wreg_i`.
  - Stores: `wreg_o` = 0.
  - On a timeout, `wreg_o` = 0.
  - Next state IDLE.
- Byte lanes (big-endian):
  - addr[1:0] = 00 selects `bus_sel_o` 1000 and bits [31:24]; 11 selects 0001 and bits [7:0].
  - Halfword at 00 selects 1100; at 10 selects 0011.
  - Word selects 1111.
  - Store data is replicated across all lanes.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment (halfword with addr[0] = 1, or word/LL/SC with addr[1:0] != 00):
  - No bus request; `align_err_o` = 1.
  - `wreg_o` = 0 and `stallreq_o` = 0; the FSM stays in IDLE.
- HI/LO outputs track their inputs in every state.

## Timing
- Reset values: FSM IDLE, `bus_req_o` = 0, counter = 0, LL bit = 0. While `rst` is 1, every output is 0.
- Reset mid-transaction: the FSM returns to IDLE at that edge and `bus_req_o` = 0 the next cycle. A late `bus_ack_i` arriving in IDLE is ignored.
- Minimum memory-op latency: 3 cycles (IDLE, BUS with ack in its first cycle, DONE). Stall lasts 2 cycles.
- An ack arriving in the same cycle the counter reaches WAIT_MAX counts as success. `bus_err_o` = 0.
- `bus_*` outputs other than `bus_req_o` are don't-care when `bus_req_o` = 0.

## Configuration
- Feature macro: `MEM_LLSC_EN`.
- Defined:
  - LL behaves as LW and sets the LL bit in DONE.
  - SC with LL bit = 1 performs SW, writes 1 to `wd_o` (`wreg_o` = 1), and clears the LL bit in DONE.
  - SC with LL bit = 0 issues no bus access, writes 0 with zero latency, and does not stall.
  - `llbit_clr_i` clears the LL bit. A set and a clear in the same cycle results in clear.
- Undefined: ops 9 and 10 are NOP, the LL bit flop and `llbit_clr_i` do not exist.

## Test plan
- Non-memory instruction: NOP with `wd_i` = 5, `wreg_i` = 1, `wdata_i` = 0x1234 -> same values on outputs in the same cycle; `stallreq_o` = 0.
- Byte load: LB at addr 0x101, `bus_rdata_i` = 0x00_80_00_00, ack in first BUS cycle -> `bus_sel_o` = 0100, stall 2 cycles, DONE `wdata_o` = 0xFFFFFF80. LBU under the same conditions -> 0x00000080.
- Halfword store: SH at 0x102, `mem_sdata_i` = 0xBEEF -> `bus_sel_o` = 0011, `bus_we_o` = 1, `bus_wdata_o` = 0xBEEFBEEF, `wreg_o` = 0 in DONE.
- Misaligned word: LW at 0x103 -> `align_err_o` = 1, `bus_req_o` stays 0, no stall.
- Bus timeout: WAIT_MAX = 4 and no ack -> `bus_req_o` high for 4 cycles, then `bus_err_o` pulse, `wreg_o` = 0. `rst` asserted in the second BUS cycle -> `bus_req_o` = 0 the next cycle.
- LL/SC (`MEM_LLSC_EN` defined): LL 0x200 then SC 0x200 -> store issued and `wdata_o` = 1. Repeating SC -> no bus access and `wdata_o` = 0.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: req/ack data-bus loads and stores with big-endian lane select and load extension.
// Define MEM_LLSC_EN to add LL/SC support (LL bit flop and the llbit_clr_i port).
module mem_access #(
    parameter int AW       = 32,
    parameter int REG_AW   = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic              whilo_i,
    input  logic [3:0]        mem_op_i,
    input  logic [AW-1:0]     mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
`ifdef MEM_LLSC_EN
    input  logic              llbit_clr_i,
`endif
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              whilo_o,
    output logic              stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [AW-1:0]     bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              align_err_o,
    output logic              bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
`ifdef MEM_LLSC_EN
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;
`endif

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t        state, state_next;
    logic          req;
    logic [7:0]    wait_cnt;
    logic          timeout;

    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdata_q;
    size_t         size_q;
    logic          sext_q;
    logic [31:0]   rdata_q;

    logic          is_load, is_store, sext, is_mem, misaligned, sc_fail, start, last_wait;
    size_t         size;
    logic [3:0]    sel;
    logic [31:0]   wdata_rep, ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
`ifdef MEM_LLSC_EN
    logic          is_ll, is_sc, llbit, ll_q, sc_q;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
`ifdef MEM_LLSC_EN
        is_ll    = 1'b0;
        is_sc    = 1'b0;
`endif
        case (mem_op_i)
            OP_LB:  begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; size = SZ_B; end
            OP_LH:  begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; size = SZ_H; end
            OP_LW:  begin is_load  = 1'b1; end
            OP_SB:  begin is_store = 1'b1; size = SZ_B; end
            OP_SH:  begin is_store = 1'b1; size = SZ_H; end
            OP_SW:  begin is_store = 1'b1; end
`ifdef MEM_LLSC_EN
            OP_LL:  begin is_load  = 1'b1; is_ll = 1'b1; end
            OP_SC:  begin is_store = 1'b1; is_sc = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = is_mem && ((size == SZ_H && mem_addr_i[0]) ||
                                   (size == SZ_W && mem_addr_i[1:0] != 2'b00));
`ifdef MEM_LLSC_EN
    assign sc_fail    = is_sc & ~llbit;
`else
    assign sc_fail    = 1'b0;
`endif
    assign start      = is_mem & ~misaligned & ~sc_fail;
    assign last_wait  = (wait_cnt == 8'(WAIT_MAX - 1));

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        sel       = 4'b1111;
        wdata_rep = mem_sdata_i;
        case (size)
            SZ_B: begin
                sel       = 4'b1000 >> mem_addr_i[1:0];
                wdata_rep = {4{mem_sdata_i[7:0]}};
            end
            SZ_H: begin
                sel       = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{mem_sdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = rdata_q[31:24];
            2'b01:   ld_byte = rdata_q[23:16];
            2'b10:   ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = addr_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size_q)
            SZ_B:    ld_data = {{24{sext_q & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUS;
            BUS:     if (bus_ack_i || last_wait) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            req      <= (state_next == BUS);
            wait_cnt <= (state == BUS && state_next == BUS) ? wait_cnt + 8'd1 : 8'd0;
            timeout  <= (state == BUS) && !bus_ack_i && last_wait;
        end
    end

    // NOTE: transaction context is always written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            addr_q  <= mem_addr_i;
            we_q    <= is_store;
            sel_q   <= sel;
            wdata_q <= wdata_rep;
            size_q  <= size;
            sext_q  <= sext;
`ifdef MEM_LLSC_EN
            ll_q    <= is_ll;
            sc_q    <= is_sc;
`endif
        end
        if (state == BUS && bus_ack_i) rdata_q <= bus_rdata_i;
    end

`ifdef MEM_LLSC_EN
    // A clear request wins over an LL completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)                           llbit <= 1'b0;
        else if (llbit_clr_i)              llbit <= 1'b0;
        else if (state == DONE && !timeout) begin
            if (ll_q)      llbit <= 1'b1;
            else if (sc_q) llbit <= 1'b0;
        end
    end
`endif

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        whilo_o     = whilo_i;
        stallreq_o  = 1'b0;
        align_err_o = 1'b0;
        bus_err_o   = 1'b0;
        bus_req_o   = req;
        bus_we_o    = we_q;
        bus_addr_o  = addr_q;
        bus_sel_o   = sel_q;
        bus_wdata_o = wdata_q;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    wreg_o      = 1'b0;
                    align_err_o = 1'b1;
                end else if (sc_fail) begin
                    wreg_o      = 1'b1;
                    wdata_o     = 32'd0;
                end else if (start) begin
                    wreg_o      = 1'b0;
                    stallreq_o  = 1'b1;
                end
            end
            BUS: begin
                wreg_o     = 1'b0;
                stallreq_o = 1'b1;
            end
            DONE: begin
                if (timeout) begin
                    wreg_o    = 1'b0;
                    bus_err_o = 1'b1;
                end
`ifdef MEM_LLSC_EN
                else if (sc_q) begin
                    wreg_o  = 1'b1;
                    wdata_o = 32'd1;
                end
`endif
                else if (we_q) wreg_o  = 1'b0;
                else           wdata_o = ld_data;
            end
            default: ;
        endcase
        if (rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = 32'd0;
            hi_o        = 32'd0;
            lo_o        = 32'd0;
            whilo_o     = 1'b0;
            stallreq_o  = 1'b0;
            align_err_o = 1'b0;
            bus_err_o   = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = 4'd0;
            bus_wdata_o = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases from the test plan plus randomized
// operations compared against a behavioural byte-lane model.
module tb_mem_access;

    localparam int AW       = 32;
    localparam int REG_AW   = 5;
    localparam int WAIT_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [REG_AW-1:0] wd, wd_o;
    logic              wreg, wreg_o;
    logic [31:0]       wdata, wdata_o;
    logic [31:0]       hi, lo, hi_o, lo_o;
    logic              whilo, whilo_o;
    logic [3:0]        mem_op;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_sdata;
    logic              stallreq_o, bus_req_o, bus_we_o;
    logic [AW-1:0]     bus_addr_o;
    logic [3:0]        bus_sel_o;
    logic [31:0]       bus_wdata_o;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    logic              align_err_o, bus_err_o;
`ifdef MEM_LLSC_EN
    logic              llbit_clr;
`endif

    mem_access #(.AW(AW), .REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
        .hi_i(hi), .lo_i(lo), .whilo_i(whilo),
        .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_sdata_i(mem_sdata),
`ifdef MEM_LLSC_EN
        .llbit_clr_i(llbit_clr),
`endif
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
        .stallreq_o(stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Model state and values observed during the last transaction.
    bit          ll_flag = 1'b0;
    logic [3:0]  last_sel;
    logic        last_we;
    logic [31:0] last_bwdata;
    logic [31:0] last_wdata;

    typedef struct packed {
        logic        mem;
        logic        store;
        logic        ll;
        logic        sc;
        logic        misal;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] ldval;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bus lanes, replicated store data and extended load value from byte arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [31:0] rd);
        exp_t   e;
        int     bytes;
        int     b;
        bit     sgn;
        longint v;
        longint span;
        e     = '0;
        bytes = 0;
        sgn   = 1'b0;
        b     = int'(a[1:0]);
        case (o)
            4'd1:  begin e.mem = 1; bytes = 1; sgn = 1; end
            4'd2:  begin e.mem = 1; bytes = 1; end
            4'd3:  begin e.mem = 1; bytes = 2; sgn = 1; end
            4'd4:  begin e.mem = 1; bytes = 2; end
            4'd5:  begin e.mem = 1; bytes = 4; end
            4'd6:  begin e.mem = 1; e.store = 1; bytes = 1; end
            4'd7:  begin e.mem = 1; e.store = 1; bytes = 2; end
            4'd8:  begin e.mem = 1; e.store = 1; bytes = 4; end
`ifdef MEM_LLSC_EN
            4'd9:  begin e.mem = 1; e.ll = 1; bytes = 4; end
            4'd10: begin e.mem = 1; e.store = 1; e.sc = 1; bytes = 4; end
`endif
            default: ;
        endcase
        if (!e.mem) return e;
        e.misal = (b % bytes) != 0;
        if (e.misal) return e;
        e.sel = 4'(((1 << bytes) - 1) << (4 - bytes - b));
        span  = longint'(1) << (8 * bytes);
        v     = (longint'(rd) >> (8 * (4 - bytes - b))) % span;
        if (sgn && v >= span / 2) v = v - span;
        e.ldval = v[31:0];
        if (bytes == 1)      e.wdat = (sd % 256) * 32'h0101_0101;
        else if (bytes == 2) e.wdat = (sd % 65536) * 32'h0001_0001;
        else                 e.wdat = sd;
        return e;
    endfunction

    // One instruction held at EX/MEM until the stage stops stalling; ack_at >= WAIT_MAX means no ack.
    task automatic run_mem(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int ack_at);
        exp_t        e;
        bit          sc_fail, tmo, done;
        int          exp_n, n;
        logic [4:0]  w;
        logic [31:0] wv;
        e       = model(o, a, sd, rd);
        sc_fail = e.sc && !ll_flag;
        tmo     = ack_at >= WAIT_MAX;
        exp_n   = tmo ? WAIT_MAX : ack_at + 1;
        w       = 5'($urandom);
        wv      = $urandom;
        @(posedge clk); #2;
        mem_op = o; mem_addr = a; mem_sdata = sd; bus_rdata = rd; bus_ack = 1'b0;
        wd = w; wreg = 1'b1; wdata = wv;
        hi = $urandom; lo = $urandom; whilo = 1'($urandom);
        #1;
        check("hi_track", hi_o, hi);
        check("lo_track", lo_o, lo);
        if (!e.mem) begin
            check("nop_wd", wd_o, w);
            check("nop_wreg", wreg_o, 1);
            check("nop_wdata", wdata_o, wv);
            check("nop_stall", stallreq_o, 0);
            check("nop_whilo", whilo_o, whilo);
        end else if (e.misal) begin
            check("mis_align", align_err_o, 1);
            check("mis_stall", stallreq_o, 0);
            check("mis_wreg", wreg_o, 0);
            @(posedge clk); #3;
            check("mis_noreq", bus_req_o, 0);
        end else if (sc_fail) begin
            check("scf_stall", stallreq_o, 0);
            check("scf_wreg", wreg_o, 1);
            check("scf_wdata", wdata_o, 0);
            last_wdata = wdata_o;
            @(posedge clk); #3;
            check("scf_noreq", bus_req_o, 0);
        end else begin
            check("idle_stall", stallreq_o, 1);
            check("idle_align", align_err_o, 0);
            n    = 0;
            done = 1'b0;
            for (int c = 0; c < WAIT_MAX + 2 && !done; c++) begin
                @(posedge clk); #2;
                if (bus_req_o) begin
                    n++;
                    if (n == 1) begin
                        last_sel    = bus_sel_o;
                        last_we     = bus_we_o;
                        last_bwdata = bus_wdata_o;
                        check("bus_sel", bus_sel_o, e.sel);
                        check("bus_we", bus_we_o, e.store);
                        check("bus_addr", bus_addr_o, a);
                        if (e.store) check("bus_wdata", bus_wdata_o, e.wdat);
                    end
                    if (n - 1 == ack_at) bus_ack = 1'b1;
                    #1;
                    check("bus_stall", stallreq_o, 1);
                end else begin
                    bus_ack = 1'b0;
                    #1;
                    done = 1'b1;
                    last_wdata = wdata_o;
                    check("done_stall", stallreq_o, 0);
                    check("done_buserr", bus_err_o, tmo);
                    check("done_wd", wd_o, w);
                    if (tmo)                    check("done_wreg_tmo", wreg_o, 0);
                    else if (e.sc)              check("done_wreg_sc", wreg_o, 1);
                    else if (e.store)           check("done_wreg_st", wreg_o, 0);
                    else                        check("done_wreg_ld", wreg_o, 1);
                    if (!tmo && e.sc)           check("done_sc_data", wdata_o, 1);
                    else if (!tmo && !e.store)  check("done_ld_data", wdata_o, e.ldval);
                    if (!tmo && e.ll)           ll_flag = 1'b1;
                    else if (!tmo && e.sc)      ll_flag = 1'b0;
                end
            end
            check("done_reached", done, 1);
            check("bus_cycles", n, exp_n);
        end
        @(posedge clk); #2;
        mem_op = 4'd0; bus_ack = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wd = 5'd7; wreg = 1'b1; wdata = 32'hDEAD_BEEF;
        hi = 32'h1111_2222; lo = 32'h3333_4444; whilo = 1'b1;
        mem_op = 4'd5; mem_addr = 32'h103; mem_sdata = 32'h5555_AAAA;
        bus_rdata = 32'hFFFF_FFFF; bus_ack = 1'b1;
`ifdef MEM_LLSC_EN
        llbit_clr = 1'b0;
`endif
        // Every output is held at zero while reset is asserted.
        repeat (2) @(posedge clk);
        #3;
        check("rst_wd", wd_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_whilo", whilo_o, 0);
        check("rst_stall", stallreq_o, 0);
        check("rst_req", bus_req_o, 0);
        check("rst_align", align_err_o, 0);
        check("rst_buserr", bus_err_o, 0);
        @(posedge clk); #2;
        rst = 1'b0; mem_op = 4'd0; bus_ack = 1'b0;

        // Non-memory pass-through in the same cycle.
        @(posedge clk); #2;
        wd = 5'd5; wreg = 1'b1; wdata = 32'h1234;
        #1;
        check("nop_wd5", wd_o, 5);
        check("nop_wreg1", wreg_o, 1);
        check("nop_data1234", wdata_o, 32'h1234);
        check("nop_nostall", stallreq_o, 0);
        run_mem(4'd11, 32'h0, 32'h0, 32'h0, 0);

        // Byte loads: sign and zero extension of lane 1.
        run_mem(4'd1, 32'h101, 32'h0, 32'h0080_0000, 0);
        check("lb_sel", last_sel, 4'b0100);
        check("lb_data", last_wdata, 32'hFFFF_FF80);
        run_mem(4'd2, 32'h101, 32'h0, 32'h0080_0000, 0);
        check("lbu_data", last_wdata, 32'h0000_0080);

        // Halfword store at the low half.
        run_mem(4'd7, 32'h102, 32'h0000_BEEF, 32'h0, 0);
        check("sh_sel", last_sel, 4'b0011);
        check("sh_we", last_we, 1);
        check("sh_wdata", last_bwdata, 32'hBEEF_BEEF);

        // Misaligned word load.
        run_mem(4'd5, 32'h103, 32'h0, 32'h0, 0);

        // Ack in the final wait cycle still succeeds; no ack times out.
        run_mem(4'd3, 32'h2, 32'h0, 32'h0000_8001, WAIT_MAX - 1);
        check("lh_last_ack", last_wdata, 32'hFFFF_8001);
        run_mem(4'd5, 32'h40, 32'h0, 32'h0, 100);
        #1;
        check("tmo_err_clears", bus_err_o, 0);

        // Reset in the second BUS cycle, then a late ack in IDLE.
        @(posedge clk); #2;
        mem_op = 4'd5; mem_addr = 32'h200; bus_ack = 1'b0;
        @(posedge clk); #3;
        check("rmt_bus1", bus_req_o, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rmt_rst_req", bus_req_o, 0);
        @(posedge clk); #2;
        rst = 1'b0; mem_op = 4'd0; bus_ack = 1'b1; wreg = 1'b1;
        #1;
        check("rmt_idle_req", bus_req_o, 0);
        check("rmt_idle_stall", stallreq_o, 0);
        @(posedge clk); #2;
        bus_ack = 1'b0;
        #1;
        check("late_ack_ignored", bus_req_o, 0);
        check("late_ack_nostall", stallreq_o, 0);
        ll_flag = 1'b0;

`ifdef MEM_LLSC_EN
        run_mem(4'd9, 32'h200, 32'h0, 32'h1122_3344, 0);
        check("ll_data", last_wdata, 32'h1122_3344);
        run_mem(4'd10, 32'h200, 32'hCAFE_F00D, 32'h0, 0);
        check("sc_ok_data", last_wdata, 1);
        check("sc_ok_we", last_we, 1);
        run_mem(4'd10, 32'h200, 32'hCAFE_F00D, 32'h0, 0);
        check("sc_fail_data", last_wdata, 0);
        run_mem(4'd9, 32'h300, 32'h0, 32'h0, 0);
        @(posedge clk); #2;
        llbit_clr = 1'b1;
        @(posedge clk); #2;
        llbit_clr = 1'b0;
        ll_flag = 1'b0;
        run_mem(4'd10, 32'h300, 32'h1, 32'h0, 0);
`else
        run_mem(4'd9, 32'h200, 32'h0, 32'h0, 0);
        run_mem(4'd10, 32'h200, 32'h0, 32'h0, 0);
`endif

        // Randomized operations, addresses, data and ack latencies.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            run_mem(4'($urandom_range(0, 15)), ra, $urandom, $urandom, $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
